// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control FSM: opcodes, ALU op codes,
// state and op-class encodings, and instruction field layout helpers.
// Instruction layout, MSB first: {opcode[2:0], src_a, dest, imm}.
package ctrl_pkg;

  localparam int unsigned OPC_W    = 3;
  localparam int unsigned ALU_OP_W = 4;

  localparam logic [OPC_W-1:0] OP_ADD    = 3'b000;
  localparam logic [OPC_W-1:0] OP_SUB    = 3'b001;
  localparam logic [OPC_W-1:0] OP_DIV    = 3'b010;
  localparam logic [OPC_W-1:0] OP_MUL    = 3'b011;
  localparam logic [OPC_W-1:0] OP_MEMCLR = 3'b100;
  localparam logic [OPC_W-1:0] OP_HALT   = 3'b101;
  localparam logic [OPC_W-1:0] OP_LOAD   = 3'b110;
  localparam logic [OPC_W-1:0] OP_STORE  = 3'b111;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b1001;
  localparam logic [ALU_OP_W-1:0] ALU_MUL = 4'b1010;
  localparam logic [ALU_OP_W-1:0] ALU_DIV = 4'b1011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_READ, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_MEMCLR, CLS_HALT, CLS_LOAD, CLS_STORE
  } op_class_e;

  // Field offsets depend on the datapath and register-address widths.
  function automatic int unsigned imm_width(int unsigned data_w, int unsigned ra_w);
    return data_w - OPC_W - 2 * ra_w;
  endfunction

  function automatic int unsigned dest_lsb(int unsigned data_w, int unsigned ra_w);
    return imm_width(data_w, ra_w);
  endfunction

  function automatic int unsigned src_lsb(int unsigned data_w, int unsigned ra_w);
    return imm_width(data_w, ra_w) + ra_w;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder.
// Ports: opcode in; op_class_c, alu_op_c, is_div_c, needs_mem_c, needs_wb_c out.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [OPC_W-1:0]    opcode,
  output op_class_e           op_class_c,
  output logic [ALU_OP_W-1:0] alu_op_c,
  output logic                is_div_c,
  output logic                needs_mem_c,
  output logic                needs_wb_c
);

  always_comb begin
    op_class_c  = CLS_ALU;
    alu_op_c    = ALU_ADD;
    is_div_c    = 1'b0;
    needs_mem_c = 1'b0;
    needs_wb_c  = 1'b0;
    case (opcode)
      OP_ADD:    begin alu_op_c = ALU_ADD; needs_wb_c = 1'b1; end
      OP_SUB:    begin alu_op_c = ALU_SUB; needs_wb_c = 1'b1; end
      OP_DIV:    begin alu_op_c = ALU_DIV; needs_wb_c = 1'b1; is_div_c = 1'b1; end
      OP_MUL:    begin alu_op_c = ALU_MUL; needs_wb_c = 1'b1; end
      OP_MEMCLR: op_class_c = CLS_MEMCLR;
      OP_HALT:   op_class_c = CLS_HALT;
      OP_LOAD:   begin op_class_c = CLS_LOAD; needs_mem_c = 1'b1; needs_wb_c = 1'b1; end
      OP_STORE:  begin op_class_c = CLS_STORE; needs_mem_c = 1'b1; end
      default:   op_class_c = CLS_ALU;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM sequencing fetch, decode, register read, ALU
// (start/done handshake), memory access and writeback for the mem/reg_bank/ALU
// datapath.
// Ports: clk, rst (async high), resume; mem side pc/instr/mem_en/mem_rw/
// mem_clear/mem_addr/mem_wdata/mem_rdata; reg_bank side src_1/src_2/rd_1/rd_2/
// opwrite/reg_write/reg_data; ALU side alu_a/alu_b/alu_op/alu_start/alu_done/
// alu_res; status halted/err/retired.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RA_W    = 2,
  parameter int unsigned PC_STEP = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                resume,
  output logic [DATA_W-1:0]   pc,
  input  logic [DATA_W-1:0]   instr,
  output logic                mem_en,
  output logic                mem_rw,
  output logic                mem_clear,
  output logic [DATA_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [RA_W-1:0]     src_1,
  output logic [RA_W-1:0]     src_2,
  input  logic [DATA_W-1:0]   rd_1,
  input  logic [DATA_W-1:0]   rd_2,
  output logic                opwrite,
  output logic [RA_W-1:0]     reg_write,
  output logic [DATA_W-1:0]   reg_data,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_start,
  input  logic                alu_done,
  input  logic [DATA_W-1:0]   alu_res,
  output logic                halted,
  output logic                err,
  output logic [CNT_W-1:0]    retired
);

  localparam int unsigned IMM_W    = imm_width(DATA_W, RA_W);
  localparam int unsigned DEST_LSB = dest_lsb(DATA_W, RA_W);
  localparam int unsigned SRC_LSB  = src_lsb(DATA_W, RA_W);
  localparam int unsigned OPC_LSB  = DATA_W - OPC_W;

  state_e              state;
  logic [DATA_W-1:0]   ir;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]   imm_q;

  logic [DATA_W-1:0]   imm_ext;
  logic [RA_W-1:0]     dest;
  logic [DATA_W-1:0]   pc_next;
  logic [CNT_W-1:0]    retired_next;

  op_class_e           op_class;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                is_div;
  logic                needs_mem;
  logic                needs_wb;

  assign imm_ext      = DATA_W'(ir[IMM_W-1:0]);
  assign dest         = ir[DEST_LSB +: RA_W];
  assign pc_next      = pc + DATA_W'(PC_STEP);
  assign retired_next = retired + CNT_W'(1);

  ctrl_decode u_decode (
    .opcode      (ir[OPC_LSB +: OPC_W]),
    .op_class_c  (op_class),
    .alu_op_c    (dec_alu_op),
    .is_div_c    (is_div),
    .needs_mem_c (needs_mem),
    .needs_wb_c  (needs_wb)
  );

  // Main sequencer; strobes default low each cycle so they form single pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      pc        <= '0;
      mem_en    <= 1'b0;
      mem_rw    <= 1'b0;
      mem_clear <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      src_1     <= '0;
      src_2     <= '0;
      opwrite   <= 1'b0;
      reg_write <= '0;
      reg_data  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_start <= 1'b0;
      halted    <= 1'b0;
      err       <= 1'b0;
      retired   <= '0;
    end else begin
      alu_start <= 1'b0;
      mem_clear <= 1'b0;
      opwrite   <= 1'b0;
      case (state)
        S_FETCH: begin
          ir    <= instr;
          state <= S_DECODE;
        end
        S_DECODE: begin
          src_1 <= ir[SRC_LSB +: RA_W];
          src_2 <= dest;
          state <= S_READ;
        end
        S_READ: begin
          a_q   <= rd_1;
          b_q   <= rd_2;
          imm_q <= imm_ext;
          if (op_class == CLS_ALU) begin
            alu_a     <= rd_1;
            alu_b     <= imm_ext;
            alu_op    <= dec_alu_op;
            // Divide by zero never reaches the ALU.
            alu_start <= !(is_div && (imm_ext == '0));
          end
          mem_clear <= (op_class == CLS_MEMCLR);
          state     <= S_EXEC;
        end
        S_EXEC: begin
          case (op_class)
            CLS_ALU: begin
              if (is_div && (imm_q == '0)) begin
                err     <= 1'b1;
                pc      <= pc_next;
                retired <= retired_next;
                state   <= S_FETCH;
              end else if (alu_done) begin
                reg_write <= dest;
                reg_data  <= alu_res;
                if (needs_wb) begin
                  opwrite <= 1'b1;
                  state   <= S_WB;
                end else begin
                  pc      <= pc_next;
                  retired <= retired_next;
                  state   <= S_FETCH;
                end
              end
            end
            CLS_MEMCLR: begin
              pc      <= pc_next;
              retired <= retired_next;
              state   <= S_FETCH;
            end
            CLS_HALT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: begin
              mem_en    <= needs_mem;
              mem_rw    <= (op_class == CLS_STORE);
              mem_addr  <= a_q + imm_q;
              mem_wdata <= b_q;
              state     <= S_MEM;
            end
          endcase
        end
        S_MEM: begin
          mem_en <= 1'b0;
          mem_rw <= 1'b0;
          if (needs_wb) begin
            reg_write <= dest;
            reg_data  <= mem_rdata;
            opwrite   <= 1'b1;
            state     <= S_WB;
          end else begin
            pc      <= pc_next;
            retired <= retired_next;
            state   <= S_FETCH;
          end
        end
        S_WB: begin
          pc      <= pc_next;
          retired <= retired_next;
          state   <= S_FETCH;
        end
        S_HALT: begin
          if (resume) begin
            halted  <= 1'b0;
            pc      <= pc_next;
            retired <= retired_next;
            state   <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl with small behavioural
// models of the instruction/data memory, register bank and a delayable ALU.
// A second instance with a large PC step and 1-bit counter exercises wrap.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, resume;
  logic [31:0] pc, instr, mem_addr, mem_wdata, mem_rdata, rd_1, rd_2;
  logic [31:0] reg_data, alu_a, alu_b, alu_res;
  logic        mem_en, mem_rw, mem_clear, opwrite, alu_start, alu_done, halted, err;
  logic [1:0]  src_1, src_2, reg_write;
  logic [3:0]  alu_op;
  logic [15:0] retired;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .resume(resume), .pc(pc), .instr(instr),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_clear(mem_clear),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .src_1(src_1), .src_2(src_2), .rd_1(rd_1), .rd_2(rd_2),
    .opwrite(opwrite), .reg_write(reg_write), .reg_data(reg_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_res(alu_res), .halted(halted), .err(err),
    .retired(retired)
  );

  // Wrap instance: every instruction is ADD r0+0->r0 with a combinational ALU.
  logic        rst2;
  logic [31:0] pc2, mem_addr2, mem_wdata2, reg_data2, alu_a2, alu_b2;
  logic        mem_en2, mem_rw2, mem_clear2, opwrite2, alu_start2, halted2, err2;
  logic [1:0]  src_12, src_22, reg_write2;
  logic [3:0]  alu_op2;
  logic [0:0]  retired2;

  multicycle_ctrl #(.DATA_W(32), .RA_W(2), .PC_STEP(32'h8000_0000), .CNT_W(1)) dut2 (
    .clk(clk), .rst(rst2), .resume(1'b0), .pc(pc2), .instr(32'h0),
    .mem_en(mem_en2), .mem_rw(mem_rw2), .mem_clear(mem_clear2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(32'h0),
    .src_1(src_12), .src_2(src_22), .rd_1(32'h0), .rd_2(32'h0),
    .opwrite(opwrite2), .reg_write(reg_write2), .reg_data(reg_data2),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_op(alu_op2), .alu_start(alu_start2),
    .alu_done(alu_start2), .alu_res(32'h0), .halted(halted2), .err(err2),
    .retired(retired2)
  );

  // Datapath models.
  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:15];
  logic [31:0] regs [0:3];
  int alu_delay = 0;
  int alu_cnt   = 0;
  int n_start   = 0;
  int n_opw     = 0;
  int passed    = 0;
  int total     = 0;

  assign instr     = imem[pc[5:0]];
  assign mem_rdata = dmem[mem_addr[3:0]];
  assign rd_1      = regs[src_1];
  assign rd_2      = regs[src_2];
  assign alu_done  = (alu_delay == 0) ? alu_start : (alu_cnt == 1);

  always_comb begin
    case (alu_op)
      4'b1000: alu_res = alu_a + alu_b;
      4'b1001: alu_res = alu_a - alu_b;
      4'b1010: alu_res = alu_a * alu_b;
      4'b1011: alu_res = (alu_b != 0) ? alu_a / alu_b : 32'h0;
      default: alu_res = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (opwrite) regs[reg_write] <= reg_data;
    if (mem_en && mem_rw) dmem[mem_addr[3:0]] <= mem_wdata;
    if (alu_start) alu_cnt <= alu_delay;
    else if (alu_cnt != 0) alu_cnt <= alu_cnt - 1;
    if (alu_start) n_start = n_start + 1;
    if (opwrite) n_opw = n_opw + 1;
  end

  function automatic logic [31:0] enc(input logic [2:0] op, input logic [1:0] s,
                                      input logic [1:0] d, input logic [24:0] imm);
    return {op, s, d, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_opwrite(output int cyc);
    cyc = 0;
    while (!opwrite && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_mem(output int cyc);
    cyc = 0;
    while (!mem_en && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1; resume = 1'b0;
    repeat (2) tick();
    total++; if (pc !== 32'h0 || retired !== 16'h0) $display("FAIL reset_pc_cnt: pc=%0h retired=%0h want 0/0", pc, retired); else passed++;
    total++; if ({err, halted, opwrite, alu_start, mem_en, mem_clear, mem_rw} !== 7'b0)
      $display("FAIL reset_strobes: got %b want 0000000", {err, halted, opwrite, alu_start, mem_en, mem_clear, mem_rw}); else passed++;
    total++; if (reg_data !== 32'h0 || alu_a !== 32'h0 || mem_addr !== 32'h0) $display("FAIL reset_data: reg_data=%0h alu_a=%0h mem_addr=%0h want 0", reg_data, alu_a, mem_addr); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_add();
    int cyc;
    wait_opwrite(cyc);
    total++; if (cyc !== 4) $display("FAIL add_latency: got %0d want 4", cyc); else passed++;
    total++; if (reg_write !== 2'd2 || reg_data !== 32'd8) $display("FAIL add_wb: reg_write=%0d reg_data=%0d want 2/8", reg_write, reg_data); else passed++;
    total++; if (alu_op !== 4'b1000 || alu_a !== 32'd5 || alu_b !== 32'd3) $display("FAIL add_alu: op=%b a=%0d b=%0d want 1000/5/3", alu_op, alu_a, alu_b); else passed++;
    tick();
    total++; if (pc !== 32'd1 || retired !== 16'd1 || opwrite !== 1'b0) $display("FAIL add_retire: pc=%0d retired=%0d opwrite=%b want 1/1/0", pc, retired, opwrite); else passed++;
  endtask

  task automatic test_mul_delayed();
    int cyc, s0;
    alu_delay = 4;
    s0 = n_start;
    wait_opwrite(cyc);
    total++; if (cyc !== 8) $display("FAIL mul_latency: got %0d want 8", cyc); else passed++;
    total++; if (n_start - s0 !== 1) $display("FAIL mul_start_pulses: got %0d want 1", n_start - s0); else passed++;
    total++; if (reg_write !== 2'd3 || reg_data !== 32'd35 || alu_op !== 4'b1010) $display("FAIL mul_wb: reg_write=%0d reg_data=%0d op=%b want 3/35/1010", reg_write, reg_data, alu_op); else passed++;
    tick();
    total++; if (pc !== 32'd2 || retired !== 16'd2) $display("FAIL mul_retire: pc=%0d retired=%0d want 2/2", pc, retired); else passed++;
    alu_delay = 0;
  endtask

  task automatic test_store_load();
    int cyc;
    wait_mem(cyc);
    total++; if (cyc !== 4 || mem_rw !== 1'b1) $display("FAIL store_mem: cyc=%0d rw=%b want 4/1", cyc, mem_rw); else passed++;
    total++; if (mem_addr !== 32'd7 || mem_wdata !== 32'd8) $display("FAIL store_addr: addr=%0d wdata=%0d want 7/8", mem_addr, mem_wdata); else passed++;
    tick();
    total++; if (mem_en !== 1'b0 || pc !== 32'd3 || dmem[7] !== 32'd8) $display("FAIL store_done: en=%b pc=%0d dmem7=%0d want 0/3/8", mem_en, pc, dmem[7]); else passed++;
    wait_mem(cyc);
    total++; if (cyc !== 4 || mem_rw !== 1'b0 || mem_addr !== 32'd7) $display("FAIL load_mem: cyc=%0d rw=%b addr=%0d want 4/0/7", cyc, mem_rw, mem_addr); else passed++;
    wait_opwrite(cyc);
    total++; if (cyc !== 1 || reg_write !== 2'd3 || reg_data !== 32'd8) $display("FAIL load_wb: cyc=%0d reg_write=%0d reg_data=%0d want 1/3/8", cyc, reg_write, reg_data); else passed++;
    tick();
    total++; if (pc !== 32'd4 || retired !== 16'd4) $display("FAIL load_retire: pc=%0d retired=%0d want 4/4", pc, retired); else passed++;
  endtask

  task automatic test_div_zero();
    int s_start, s_opw, cyc;
    s_start = n_start; s_opw = n_opw;
    repeat (4) tick();
    total++; if (pc !== 32'd5 || retired !== 16'd5 || err !== 1'b1) $display("FAIL div0_retire: pc=%0d retired=%0d err=%b want 5/5/1", pc, retired, err); else passed++;
    total++; if (n_start !== s_start || n_opw !== s_opw) $display("FAIL div0_no_pulses: starts=%0d writes=%0d want 0/0", n_start - s_start, n_opw - s_opw); else passed++;
    wait_opwrite(cyc);
    total++; if (cyc !== 4 || reg_data !== 32'd4 || alu_op !== 4'b1001) $display("FAIL sub_wb: cyc=%0d data=%0d op=%b want 4/4/1001", cyc, reg_data, alu_op); else passed++;
    total++; if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err); else passed++;
    tick();
    wait_opwrite(cyc);
    total++; if (cyc !== 4 || reg_data !== 32'd2 || alu_op !== 4'b1011) $display("FAIL div_wb: cyc=%0d data=%0d op=%b want 4/2/1011", cyc, reg_data, alu_op); else passed++;
    tick();
  endtask

  task automatic test_halt();
    repeat (4) tick();
    total++; if (halted !== 1'b1 || pc !== 32'd7) $display("FAIL halt_enter: halted=%b pc=%0d want 1/7", halted, pc); else passed++;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (halted !== 1'b1 || pc !== 32'd7) $display("FAIL halt_hold: cycle %0d halted=%b pc=%0d want 1/7", i, halted, pc); else passed++;
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    total++; if (halted !== 1'b0 || pc !== 32'd8) $display("FAIL halt_resume: halted=%b pc=%0d want 0/8", halted, pc); else passed++;
  endtask

  task automatic test_memclr();
    int s_opw;
    s_opw = n_opw;
    repeat (3) tick();
    total++; if (mem_clear !== 1'b1) $display("FAIL memclr_pulse: got %b want 1", mem_clear); else passed++;
    tick();
    total++; if (mem_clear !== 1'b0 || pc !== 32'd9 || n_opw !== s_opw) $display("FAIL memclr_exit: clr=%b pc=%0d writes=%0d want 0/9/0", mem_clear, pc, n_opw - s_opw); else passed++;
  endtask

  task automatic test_rst_mid_exec();
    int s_opw, cyc;
    alu_delay = 4;
    repeat (3) tick();
    total++; if (alu_start !== 1'b1) $display("FAIL rst_pre_exec: alu_start=%b want 1", alu_start); else passed++;
    tick();
    s_opw = n_opw;
    #2 rst = 1'b1;
    #1;
    total++; if (pc !== 32'h0 || retired !== 16'h0 || err !== 1'b0 || halted !== 1'b0) $display("FAIL rst_async_state: pc=%0h retired=%0d err=%b halted=%b want 0", pc, retired, err, halted); else passed++;
    total++; if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== 4'h0 || reg_data !== 32'h0 || opwrite !== 1'b0) $display("FAIL rst_async_data: a=%0h b=%0h op=%0h data=%0h opw=%b want 0", alu_a, alu_b, alu_op, reg_data, opwrite); else passed++;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    alu_delay = 0;
    wait_opwrite(cyc);
    total++; if (cyc !== 4 || reg_data !== 32'd8 || n_opw !== s_opw) $display("FAIL rst_restart: cyc=%0d data=%0d stray_writes=%0d want 4/8/0", cyc, reg_data, n_opw - s_opw); else passed++;
  endtask

  task automatic test_wrap();
    rst2 = 1'b0;
    repeat (5) tick();
    total++; if (pc2 !== 32'h8000_0000 || retired2 !== 1'b1) $display("FAIL wrap_first: pc=%0h retired=%0d want 80000000/1", pc2, retired2); else passed++;
    repeat (5) tick();
    total++; if (pc2 !== 32'h0 || retired2 !== 1'b0) $display("FAIL wrap_second: pc=%0h retired=%0d want 0/0", pc2, retired2); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
    regs[0] = 32'd0; regs[1] = 32'd5; regs[2] = 32'd0; regs[3] = 32'd0;
    imem[0] = enc(3'b000, 2'd1, 2'd2, 25'd3);  // ADD r1+3 -> r2
    imem[1] = enc(3'b011, 2'd1, 2'd3, 25'd7);  // MUL r1*7 -> r3
    imem[2] = enc(3'b111, 2'd1, 2'd2, 25'd2);  // STORE r2 @ r1+2
    imem[3] = enc(3'b110, 2'd1, 2'd3, 25'd2);  // LOAD r3 <- @ r1+2
    imem[4] = enc(3'b010, 2'd1, 2'd2, 25'd0);  // DIV by zero
    imem[5] = enc(3'b001, 2'd1, 2'd0, 25'd1);  // SUB r1-1 -> r0
    imem[6] = enc(3'b010, 2'd1, 2'd0, 25'd2);  // DIV r1/2 -> r0
    imem[7] = enc(3'b101, 2'd0, 2'd0, 25'd0);  // HALT
    imem[8] = enc(3'b100, 2'd0, 2'd0, 25'd0);  // MEMCLR
    imem[9] = enc(3'b011, 2'd1, 2'd3, 25'd7);  // MUL, interrupted by reset

    test_reset();
    test_add();
    test_mul_delayed();
    test_store_load();
    test_div_zero();
    test_halt();
    test_memclr();
    test_rst_mid_exec();
    test_wrap();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
